// File: rtl/coloring_fb_pkg.sv
// Shared types and field layout for the colouring frame-buffer stage.
package coloring_fb_pkg;

  typedef enum logic [2:0] {CLEAR, IDLE, HDR, PIX, DUMP_RD, DUMP_OUT} state_t;

  localparam int DATA_W    = 32;
  localparam int X_LSB     = 0;
  localparam int Y_LSB     = 8;
  localparam int COLOR_LSB = 16;
  localparam int EOF_BIT   = 31;

  function automatic int fb_addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/coloring_fb_if.sv
// Pixel stream in from z-culling and packed frame-buffer words out, each with valid/ready.
interface coloring_fb_if;
  import coloring_fb_pkg::*;

  logic [DATA_W-1:0] din;
  logic              vld_in;
  logic              rdy_upward;
  logic [DATA_W-1:0] dout;
  logic              vld_out;
  logic              rdy_downward;

  modport master (output din, vld_in, rdy_downward, input rdy_upward, dout, vld_out);
  modport slave  (input din, vld_in, rdy_downward, output rdy_upward, dout, vld_out);
endinterface

// File: rtl/fb_ram_1r1w.sv
// 8-bit wide simple dual-port RAM: one write port, one registered read port, read-first.
module fb_ram_1r1w #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/coloring_fb_stage.sv
// Writes pixel colours into an 8-bit frame buffer; on EOF streams it out as packed words, clearing as it reads.
// One output word per 6 cycles, held until rdy_downward; `COLORING_FB_STATS_EN adds written/dropped pixel counters.
module coloring_fb_stage
  import coloring_fb_pkg::*;
#(
  parameter int FB_W         = 256,
  parameter int FB_H         = 256,
  parameter int PAYLOAD_BITS = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ap_start,
  coloring_fb_if.slave   io
`ifdef COLORING_FB_STATS_EN
  ,
  output logic [31:0]    pix_written,
  output logic [31:0]    pix_dropped
`endif
);

  localparam int ADDR_W = fb_addr_w(FB_W, FB_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

  state_t            state, next_state;
  logic [ADDR_W-1:0] clr_cnt, d, d_next, dump_addr, pix_addr;
  logic [15:0]       remaining;
  logic [2:0]        rd_cnt;
  logic [31:0]       dout_q;
  logic              vld_out_q;
  logic              rdy, accept, pix_ok, frame_done;
  logic              we;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [7:0]        wdata, rdata;
  logic [7:0]        px_x, px_y, px_color;
  logic              unused_din;

  assign px_x       = io.din[X_LSB +: 8];
  assign px_y       = io.din[Y_LSB +: 8];
  assign px_color   = io.din[COLOR_LSB +: 8];
  assign unused_din = ^io.din[30:24];

  assign pix_ok     = ({1'b0, px_x} < 9'(FB_W)) && ({1'b0, px_y} < 9'(FB_H));
  assign pix_addr   = ADDR_W'(px_y) * ADDR_W'(FB_W) + ADDR_W'(px_x);
  // d is always word aligned, so the low two bits come straight from the read counter
  assign dump_addr  = {d[ADDR_W-1:2], rd_cnt[1:0]};
  assign d_next     = d + ADDR_W'(4);
  assign accept     = io.vld_in & rdy;
  assign frame_done = (state == DUMP_OUT) && io.rdy_downward && (d_next == '0);

  assign io.rdy_upward = rdy;
  assign io.dout       = dout_q;
  assign io.vld_out    = vld_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    rdy        = 1'b0;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    raddr      = '0;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt;
        if (clr_cnt == LAST_ADDR) next_state = IDLE;
      end
      IDLE: if (ap_start) next_state = HDR;
      HDR: begin
        rdy = 1'b1;
        if (io.vld_in) begin
          if (io.din[EOF_BIT])         next_state = DUMP_RD;
          else if (io.din[15:0] != '0) next_state = PIX;
        end
      end
      PIX: begin
        rdy   = 1'b1;
        we    = io.vld_in & pix_ok;
        waddr = pix_addr;
        wdata = px_color;
        if (io.vld_in && remaining == 16'd1) next_state = HDR;
      end
      DUMP_RD: begin
        if (rd_cnt != 3'd4) begin
          we    = 1'b1;
          waddr = dump_addr;
          raddr = dump_addr;
        end else begin
          next_state = DUMP_OUT;
        end
      end
      DUMP_OUT: if (io.rdy_downward) next_state = (d_next == '0) ? HDR : DUMP_RD;
      default:  next_state = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt   <= '0;
      remaining <= '0;
      d         <= '0;
      rd_cnt    <= '0;
      dout_q    <= '0;
      vld_out_q <= 1'b0;
    end else begin
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (state == HDR && accept && !io.din[EOF_BIT]) remaining <= io.din[15:0];
      if (state == PIX && accept) remaining <= remaining - 16'd1;
      if (state == DUMP_RD) begin
        rd_cnt <= (rd_cnt == 3'd4) ? 3'd0 : rd_cnt + 3'd1;
        // read data trails its address by one cycle
        case (rd_cnt)
          3'd1:    dout_q[7:0]   <= rdata;
          3'd2:    dout_q[15:8]  <= rdata;
          3'd3:    dout_q[23:16] <= rdata;
          3'd4:    dout_q[31:24] <= rdata;
          default: ;
        endcase
        if (rd_cnt == 3'd4) vld_out_q <= 1'b1;
      end
      if (state == DUMP_OUT && io.rdy_downward) begin
        vld_out_q <= 1'b0;
        d         <= d_next;
      end
    end
  end

`ifdef COLORING_FB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_written <= '0;
      pix_dropped <= '0;
    end else if (frame_done) begin
      pix_written <= '0;
      pix_dropped <= '0;
    end else if (state == PIX && accept) begin
      if (pix_ok && pix_written != '1)   pix_written <= pix_written + 32'd1;
      if (!pix_ok && pix_dropped != '1)  pix_dropped <= pix_dropped + 32'd1;
    end
  end
`else
  logic unused_frame_done;
  assign unused_frame_done = frame_done;
`endif

  fb_ram_1r1w #(.AW(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_coloring_fb_stage.sv
// Directed frame vectors plus reset/cadence/backpressure sequences for coloring_fb_stage on an 8x4 buffer.
module tb_coloring_fb_stage;

  logic clk = 1'b0;
  logic reset;
  logic ap_start;
`ifdef COLORING_FB_STATS_EN
  logic [31:0] pix_written, pix_dropped;
`endif

  coloring_fb_if io();

  coloring_fb_stage #(.FB_W(8), .FB_H(4), .PAYLOAD_BITS(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .ap_start (ap_start),
    .io       (io)
`ifdef COLORING_FB_STATS_EN
    ,
    .pix_written (pix_written),
    .pix_dropped (pix_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       nin;
    logic [7:0][31:0] win;
    logic [7:0][31:0] expw;
    logic             toggle;
    logic [7:0]       exp_wr;
    logic [7:0]       exp_dr;
  } frame_t;

  localparam logic [31:0] EOF = 32'h8000_0000;

  frame_t           frames[6];
  logic [7:0][31:0] zero_words;
  int               vectors = 0;
  int               miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // entered and left at a negedge
  task automatic send_word(input logic [31:0] w);
    int n = 0;
    io.din    = w;
    io.vld_in = 1'b1;
    while (!io.rdy_upward && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!io.rdy_upward) timeout("send_word");
    @(negedge clk);
    io.vld_in = 1'b0;
    io.din    = '0;
  endtask

  task automatic recv_words(input logic [7:0][31:0] expw, input int nw, input bit tog);
    int k = 0, cyc = 0, last_acc = -1, guard = 0;
    bit held = 1'b0;
    logic [31:0] held_dat = '0;
    while (k < nw && guard < 400) begin
      io.rdy_downward = tog ? cyc[0] : 1'b1;
      if (held) begin
        check("hold_vld", 32'(io.vld_out), 32'd1);
        check("hold_dat", io.dout, held_dat);
      end
      held = 1'b0;
      if (io.vld_out) begin
        if (io.rdy_downward) begin
          check($sformatf("word%0d", k), io.dout, expw[k]);
          if (!tog && last_acc >= 0) check("cadence", cyc - last_acc, 32'd6);
          last_acc = cyc;
          k++;
        end else begin
          held     = 1'b1;
          held_dat = io.dout;
        end
      end
      @(negedge clk);
      cyc++;
      guard++;
    end
    if (k < nw) timeout("recv_words");
    io.rdy_downward = 1'b0;
  endtask

  initial begin
    int n;
    zero_words = '0;
    foreach (frames[i]) frames[i] = '0;
    // immediate EOF: empty buffer
    frames[0].nin = 1;  frames[0].win[0] = EOF;
    // two pixels at opposite corners of the dump
    frames[1].nin = 4;
    frames[1].win[0] = 32'h0000_0002; frames[1].win[1] = 32'h00AA_0001;
    frames[1].win[2] = 32'h0055_0306; frames[1].win[3] = EOF;
    frames[1].expw[0] = 32'h0000_AA00; frames[1].expw[7] = 32'h0055_0000;
    frames[1].exp_wr = 2;
    frames[2] = frames[1];
    frames[2].toggle = 1'b1;
    // ignored top byte set; earlier frame data must be gone
    frames[3].nin = 3;
    frames[3].win[0] = 32'h0000_0001; frames[3].win[1] = 32'h1211_0000; frames[3].win[2] = EOF;
    frames[3].expw[0] = 32'h0000_0011;
    frames[3].exp_wr = 1;
    // N=0 header, then two out-of-range pixels and one in range
    frames[4].nin = 6;
    frames[4].win[0] = 32'h0000_0000; frames[4].win[1] = 32'h0000_0003;
    frames[4].win[2] = 32'h00CC_0008; frames[4].win[3] = 32'h00DD_0400;
    frames[4].win[4] = 32'h007F_0202; frames[4].win[5] = EOF;
    frames[4].expw[4] = 32'h007F_0000;
    frames[4].exp_wr = 1; frames[4].exp_dr = 2;
    // same address twice: last write wins
    frames[5].nin = 4;
    frames[5].win[0] = 32'h0000_0002; frames[5].win[1] = 32'h0001_0103;
    frames[5].win[2] = 32'h0002_0103; frames[5].win[3] = EOF;
    frames[5].expw[2] = 32'h0200_0000;
    frames[5].exp_wr = 2;

    reset = 1'b1; ap_start = 1'b0;
    io.vld_in = 1'b0; io.din = '0; io.rdy_downward = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy",  32'(io.rdy_upward), 32'd0);
    check("rst_vld",  32'(io.vld_out), 32'd0);
    check("rst_dout", io.dout, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("idle_rdy", 32'(io.rdy_upward), 32'd0);
    ap_start = 1'b1;
    @(negedge clk);
    check("start_rdy", 32'(io.rdy_upward), 32'd1);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < int'(frames[f].nin); i++) send_word(frames[f].win[i]);
`ifdef COLORING_FB_STATS_EN
      check($sformatf("f%0d_written", f), pix_written, 32'(frames[f].exp_wr));
      check($sformatf("f%0d_dropped", f), pix_dropped, 32'(frames[f].exp_dr));
`endif
      recv_words(frames[f].expw, 8, frames[f].toggle);
      check($sformatf("f%0d_end_rdy", f), 32'(io.rdy_upward), 32'd1);
      check($sformatf("f%0d_end_vld", f), 32'(io.vld_out), 32'd0);
    end

    // reset while the fourth dump word is pending
    send_word(32'h0000_0001);
    send_word(32'h0099_0305);
    send_word(EOF);
    recv_words(zero_words, 3, 1'b0);
    n = 0;
    while (!io.vld_out && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pend4_vld", 32'(io.vld_out), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_vld",  32'(io.vld_out), 32'd0);
    check("mid_rst_dout", io.dout, 32'd0);
    check("mid_rst_rdy",  32'(io.rdy_upward), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!io.rdy_upward && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("clear_cycles", n, 32'd33);
`ifdef COLORING_FB_STATS_EN
    check("rst_written", pix_written, 32'd0);
`endif
    send_word(EOF);
    recv_words(zero_words, 8, 1'b0);
    check("post_rst_rdy", 32'(io.rdy_upward), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coloring_fb_stage.md
Name: coloring_fb_stage

Overview:
Downstream consumer of the z-culling stage in the rendering pipeline. It takes the 32-bit pixel stream produced by z-culling and writes each pixel's colour into an internal 8-bit frame buffer. On an end-of-frame marker it streams the whole buffer out as packed 32-bit words toward the leaf interface output port. It clears the buffer as it streams it out, ready for the next frame.

Parameters:
FB_W, 256, frame width in pixels (power of 2, max 256)
FB_H, 256, frame height in pixels (power of 2, max 256); FB_W*FB_H must be a multiple of 4
PAYLOAD_BITS, 32, stream word width (fixed 32; other values unsupported)

Ports:
clk  in  1  sole clock
reset  in  1  asynchronous, active-high reset
ap_start  in  1  level start; block leaves IDLE on first cycle it is high
din  in  32  input word from z-culling
vld_in  in  1  din valid
rdy_upward  out  1  ready to z-culling; transfer when vld_in & rdy_upward
dout  out  32  packed frame-buffer word (byte0 = lowest pixel address)
vld_out  out  1  dout valid
rdy_downward  in  1  downstream ready; transfer when vld_out & rdy_downward

Behaviour:
- Input format:
  - Header word: bit31=1 means end-of-frame (EOF); otherwise bits[15:0] = N, the pixel count of the next group.
  - Pixel word: x=[7:0], y=[15:8], color=[23:16], bits[31:24] ignored.
- Memory: FB_W*FB_H x 8 array, address = y*FB_W + x, 1-cycle synchronous read, read-first on simultaneous write.
- Reset (asynchronous):
  - rdy_upward=0, vld_out=0, dout=0; all counters 0; state=CLEAR.
  - Reset mid-frame or mid-dump abandons all work; the partial dump word is discarded.
- States:
  - CLEAR: writes 0 to one address per cycle, FB_W*FB_H cycles, then -> IDLE.
  - IDLE: rdy_upward=0; when ap_start=1 -> HDR.
  - HDR: rdy_upward=1.
    - Accepted EOF word -> DUMP_RD.
    - Accepted N=0 -> stay in HDR.
    - Accepted N>0 -> load remaining=N, go to PIX.
  - PIX: rdy_upward=1. Each accepted word writes color to fb[addr] in the same cycle and decrements remaining; at remaining==1 with accept -> HDR.
    - x>=FB_W or y>=FB_H: word is consumed but not written (dropped).
    - Later writes to the same address overwrite earlier ones.
  - DUMP_RD: rdy_upward=0.
    - Issues 4 consecutive reads from dump address d..d+3, writing 0 to each address as it is read (clear-on-read).
    - Packs returned bytes into the output register, byte k = fb[d+k].
    - One cycle after the 4th read returns: vld_out=1 -> DUMP_OUT.
  - DUMP_OUT: holds dout/vld_out stable until rdy_downward.
    - On accept: d+=4, vld_out=0.
    - If d wraps to 0 -> HDR (next frame, ap_start not re-checked); else -> DUMP_RD.
- Dump emits exactly FB_W*FB_H/4 words per EOF. Rate is one word per 6 cycles with rdy_downward held high.
- vld_in ignored in CLEAR, IDLE and DUMP_*; no input word is consumed there.
- vld_out never deasserts without a handshake.

Optional Feature:
COLORING_FB_STATS_EN
- Defined: adds outputs pix_written[31:0] and pix_dropped[31:0].
  - pix_written counts every in-range write; pix_dropped counts out-of-range pixel words.
  - Both clear on reset and on leaving DUMP_OUT at frame end; both saturate at 2^32-1.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package coloring_fb_pkg:
  - State enum {CLEAR, IDLE, HDR, PIX, DUMP_RD, DUMP_OUT}.
  - Field offsets: X_LSB=0, Y_LSB=8, COLOR_LSB=16, EOF_BIT=31.
  - Helper for address width, $clog2(FB_W*FB_H).
- One sub-module, fb_ram_1r1w: synchronous read-first 8-bit RAM, keeping the inferred-BRAM template separate from the control FSM.

Test Plan:
Use FB_W=8, FB_H=4 (32 pixels, 8 dump words) throughout.
1. Reset, then ap_start=1. -> rdy_upward stays 0 for 32 cycles of CLEAR; then, with ap_start high, rdy_upward=1 from HDR. Immediate EOF -> 8 words of 0x00000000.
2. Header N=2, pixels {x=1,y=0,c=0xAA}, {x=6,y=3,c=0x55}, then EOF. -> word0=0x0000AA00, word7=0x00550000, all other words 0.
3. Same frame as 2 with rdy_downward toggling 1/0 every cycle. -> identical 8 words, dout stable while vld_out & !rdy_downward.
4. Second frame: N=1 {x=0,y=0,c=0x11} then EOF. -> word0=0x00000011, rest 0, proving clear-on-read.
5. N=3 with {x=8,y=0}, {x=0,y=4}, {x=2,y=2,c=0x7F}. -> only fb[18] written, so word4 = 0x007F0000. With COLORING_FB_STATS_EN: pix_written=1, pix_dropped=2.
6. Assert reset mid-dump after 3 words. -> vld_out=0 immediately; after CLEAR and ap_start, EOF yields all-zero words.
